// File: rtl/credit_rr_arbiter.sv
// Round-robin arbiter sharing one credit-based FIFO write port among NUM_REQ requesters.
// Optional sticky credit-overflow flag (credit_err) is enabled by defining CREDIT_ARB_ERR_EN.
module credit_rr_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_CREDITS = 8,
    localparam int unsigned ID_W       = $clog2(NUM_REQ),
    localparam int unsigned CNT_W      = $clog2(MAX_CREDITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]               out_src,
    input  logic                          credit_return,
    output logic [CNT_W-1:0]              credit_count
`ifdef CREDIT_ARB_ERR_EN
    ,
    output logic                          credit_err
`endif
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CREDITS);

    logic [CNT_W-1:0]      credit_q, credit_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_W-1:0]       out_src_q, out_src_d;

    logic                  has_credit;
    logic                  at_max;
    logic                  issue;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       gnt_idx;
    logic [DATA_WIDTH-1:0] gnt_data;

    function automatic logic [ID_W-1:0] wrap_add(logic [ID_W-1:0] base, int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return ID_W'(sum % NUM_REQ);
    endfunction

    assign has_credit = (credit_q != '0);
    assign at_max     = (credit_q == MaxCnt);

    // Grant depends only on registered credit state, never on credit_return.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        gnt_data = '0;
        issue    = 1'b0;
        if (rst_n && has_credit) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!issue && req_valid[wrap_add(rr_ptr_q, k)]) begin
                    issue          = 1'b1;
                    gnt_idx        = wrap_add(rr_ptr_q, k);
                    grant[gnt_idx] = 1'b1;
                    gnt_data       = req_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        credit_d = credit_q;
        unique case ({issue, credit_return})
            2'b10:   credit_d = credit_q - CNT_W'(1);
            2'b01:   if (!at_max) credit_d = credit_q + CNT_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_comb begin
        rr_ptr_d    = issue ? wrap_add(gnt_idx, 1) : rr_ptr_q;
        out_valid_d = issue;
        out_data_d  = issue ? gnt_data : out_data_q;
        out_src_d   = issue ? gnt_idx : out_src_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_q    <= MaxCnt;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            credit_q    <= credit_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign req_ready    = grant;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_src      = out_src_q;
    assign credit_count = credit_q;

`ifdef CREDIT_ARB_ERR_EN
    logic err_q, err_d;

    // A return with a full counter and no issue means the FIFO popped a beat we never sent.
    assign err_d = err_q | (credit_return && at_max && !issue);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign credit_err = err_q;
`endif

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_credit_max:   assert property (@(posedge clk) disable iff (!rst_n) credit_q <= MaxCnt);

endmodule

// File: tb/tb_credit_rr_arbiter.sv
// Directed self-checking bench for credit_rr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_CREDITS=8).
module tb_credit_rr_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXC = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_data;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_src;
    logic              credit_return;
    logic [3:0]        credit_count;
`ifdef CREDIT_ARB_ERR_EN
    logic              credit_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    int beats;

    always #5 clk = ~clk;

    credit_rr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_CREDITS(MAXC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_src      (out_src),
        .credit_return(credit_return),
        .credit_count (credit_count)
`ifdef CREDIT_ARB_ERR_EN
        ,
        .credit_err   (credit_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req_valid     = '0;
        credit_return = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] beat(int i);
        return 32'hD000_0000 + 32'(i) * 32'h11;
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = beat(i);

        // Reset with requests pending: nothing may be granted.
        rst_n         = 1'b0;
        req_valid     = '1;
        credit_return = 1'b0;
        tick();
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_credit", 32'(credit_count), MAXC);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);
        tick();

        rst_n     = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_ready", 32'(req_ready), 32'h0);
            check("idle_credit", 32'(credit_count), MAXC);
            check("idle_out_valid", 32'(out_valid), 32'h0);
            tick();
        end

        // All requesters valid, credits returned from cycle 2 on.
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            credit_return = (c >= 2);
            @(negedge clk);
            check("rr_ready", 32'(req_ready), 32'(1) << (c % 4));
            check("rr_credit", 32'(credit_count), (c == 0) ? 32'd8 : (c == 1) ? 32'd7 : 32'd6);
            if (c >= 1) begin
                check("rr_out_valid", 32'(out_valid), 32'h1);
                check("rr_out_src", 32'(out_src), 32'((c - 1) % 4));
                check("rr_out_data", out_data, beat((c - 1) % 4));
            end
            tick();
        end
        req_valid     = '0;
        credit_return = 1'b0;

        // Single requester drains all credits, then one returned credit yields one beat.
        do_reset();
        req_valid = 4'b0100;
        beats     = 0;
        for (int c = 0; c < 13; c++) begin
            credit_return = (c == 9);
            @(negedge clk);
            check("drain_ready", 32'(req_ready), (c <= 7 || c == 10) ? 32'h4 : 32'h0);
            check("drain_credit", 32'(credit_count),
                  (c <= 8) ? 32'(8 - c) : (c == 10) ? 32'd1 : 32'd0);
            check("drain_out_valid", 32'(out_valid),
                  ((c >= 1 && c <= 8) || c == 11) ? 32'h1 : 32'h0);
            if (out_valid) begin
                beats++;
                check("drain_out_src", 32'(out_src), 32'd2);
            end
            tick();
        end
        credit_return = 1'b0;
        @(negedge clk);
        check("drain_beats", 32'(beats), 32'd9);
        check("hold_out_data", out_data, beat(2));
        check("hold_out_src", 32'(out_src), 32'd2);
        tick();

        // Grant and return in the same cycle at count 3.
        do_reset();
        req_valid = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            credit_return = (c == 5);
            @(negedge clk);
            if (c == 5) begin
                check("both_credit_before", 32'(credit_count), 32'd3);
                check("both_ready", 32'(req_ready), 32'h4);
            end
            if (c == 6) check("both_credit_after", 32'(credit_count), 32'd3);
            tick();
        end
        req_valid     = '0;
        credit_return = 1'b0;

        // Return at full count saturates.
        do_reset();
        credit_return = 1'b1;
        @(negedge clk);
        check("ovf_credit_before", 32'(credit_count), 32'd8);
        tick();
        credit_return = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ovf_credit", 32'(credit_count), 32'd8);
`ifdef CREDIT_ARB_ERR_EN
            check("ovf_err_sticky", 32'(credit_err), 32'h1);
`endif
            tick();
        end
        do_reset();
        @(negedge clk);
        check("ovf_credit_rst", 32'(credit_count), 32'd8);
`ifdef CREDIT_ARB_ERR_EN
        check("ovf_err_cleared", 32'(credit_err), 32'h0);
`endif
        tick();

        // Reset mid-stream at count 2.
        do_reset();
        req_valid = '1;
        for (int c = 0; c < 6; c++) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_credit_pre", 32'(credit_count), 32'd2);
        check("mid_out_valid_pre", 32'(out_valid), 32'h1);
        check("mid_out_src_pre", 32'(out_src), 32'd1);
        check("mid_ready_in_rst", 32'(req_ready), 32'h0);
        tick();
        @(negedge clk);
        check("mid_out_valid", 32'(out_valid), 32'h0);
        check("mid_credit", 32'(credit_count), 32'd8);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_first_grant", 32'(req_ready), 32'h1);
        tick();
        @(negedge clk);
        check("mid_first_src", 32'(out_src), 32'd0);
        check("mid_second_grant", 32'(req_ready), 32'h2);
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/credit_rr_arbiter.md
# credit_rr_arbiter

Round-robin arbiter that shares one credit-based FIFO write port among NUM_REQ requesters. It tracks the downstream FIFO's free-slot credits locally and grants at most one requester per cycle, only when a credit is held. The winning beat goes out through a registered output stage to the FIFO write side. The FIFO's read-side pops return credits through a one-cycle pulse.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 32: beat width.
- MAX_CREDITS, 8: downstream FIFO depth; credit counter reset value.
- ID_W, $clog2(NUM_REQ) (localparam): source-ID width.
- CNT_W, $clog2(MAX_CREDITS+1) (localparam): credit counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester valid.
- req_ready  out  NUM_REQ  per-requester ready; one-hot or zero.
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  registered write strobe to the FIFO.
- out_data  out  DATA_WIDTH  registered beat.
- out_src  out  ID_W  registered ID of the requester that produced out_data.
- credit_return  in  1  one pulse per FIFO pop; returns one credit.
- credit_count  out  CNT_W  credits currently held.

## Operation
- Grant, combinational:
  - eligible[i] = req_valid[i] && (credit_count != 0).
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - req_ready[i] = 1 only for the first eligible index found.
- Handshake: req_valid[i] && req_ready[i]. In the same cycle:
  - the beat is latched into out_data and the index into out_src;
  - rr_ptr <= (i+1) mod NUM_REQ;
  - one credit is consumed.
- No handshake: out_valid <= 0. out_data and out_src hold their last values. rr_ptr holds.
- Credit counter:
  - issue only: credit_count - 1.
  - credit_return only: credit_count + 1.
  - both: unchanged.
  - neither: unchanged.
- credit_count never underflows: a grant requires a nonzero count.
- Overflow: credit_return while credit_count == MAX_CREDITS and no issue that cycle leaves the count saturated at MAX_CREDITS.
- Requesters may drop req_valid without a handshake. A granted requester that deasserts loses nothing; the pointer does not move.
- The downstream FIFO must accept every out_valid beat. Credits guarantee this.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, credit_count=MAX_CREDITS, rr_ptr=0, req_ready=0 during reset.
- Latency: handshake in cycle N gives out_valid=1 in cycle N+1.
- Throughput: one beat per cycle while credits remain.
- Credits are spent in the handshake cycle, not the output cycle, so credit_count reflects in-flight beats immediately.
- credit_return in cycle N is visible in credit_count at N+1. A grant can use that credit in cycle N+1.
- With credit_count=0, a credit_return in cycle N enables a grant in N+1. It does not enable one in N: there is no combinational path from credit_return to req_ready.
- Reset mid-operation: any in-flight out_valid is dropped, credits revert to MAX_CREDITS, and the pointer goes to 0. The FIFO must be reset alongside.
- Wrap-around: rr_ptr = NUM_REQ-1 followed by a grant of NUM_REQ-1 sets rr_ptr=0.

## Configuration
- CREDIT_ARB_ERR_EN defined:
  - Adds output port credit_err (1 bit), sticky, reset to 0.
  - credit_err is set when credit_return arrives with credit_count == MAX_CREDITS and no issue in the same cycle.
  - It clears only on reset.
- Not defined:
  - No credit_err port.
  - Overflow saturates silently.
  - All other behaviour is identical.

## Test plan
- Reset, all req_valid=0 -> credit_count=8, out_valid=0, req_ready=0 for 10 cycles.
- req_valid=4'b1111 held, credit_return pulsed each cycle from cycle 2 onward:
  - required grant order 0,1,2,3,0,1,...;
  - out_src follows the same order one cycle later;
  - no cycle without a beat.
- Only requester 2 valid, no credit_return:
  - exactly 8 beats are issued, then req_ready=0 and credit_count=0;
  - a single credit_return leads to exactly one more beat, granted one cycle later.
- Grant and credit_return in the same cycle at credit_count=3 -> credit_count stays 3.
- credit_return at credit_count=8 with no traffic:
  - credit_count stays 8;
  - with CREDIT_ARB_ERR_EN, credit_err=1 next cycle and stays high until rst_n=0.
- rst_n=0 asserted mid-stream with credit_count=2 -> next cycle out_valid=0, credit_count=8, and the first grant after release goes to requester 0.
